// File: rtl/mem_bank_pipe.sv
// rtl/mem_bank_pipe.sv - parametrised single-port RAM bank with byte enables and pipelined reads
// Define MEM_CLEAR_EN to zero the whole array after reset before any request is accepted.
module mem_bank_pipe #(
   parameter int WORD   = 32,
   parameter int ADDR   = 16,
   parameter int DEPTH  = 65536,
   parameter int RD_LAT = 1,
   localparam int BE_W  = WORD / 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [ADDR-1:0] req_addr,
   input  logic [WORD-1:0] req_wdata,
   input  logic [BE_W-1:0] req_be,
   output logic            rd_valid,
   output logic [WORD-1:0] rd_data,
   output logic            busy
);
   localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR:0] DEPTH_L  = (ADDR + 1)'(DEPTH);
   localparam logic [0:0]    ST_CLEAR = 1'b0;
   localparam logic [0:0]    ST_READY = 1'b1;

   logic [0:0]      state;
   logic [WORD-1:0] mem [DEPTH];
   logic            acc;
   logic            in_range;
   logic            rd_acc;
   logic            wr_acc;
   logic [AW-1:0]   idx;
   logic [WORD-1:0] rd_word;
   logic [RD_LAT-1:0] v_pipe;
   logic [WORD-1:0] d_pipe [RD_LAT];

   // req_ready is a pure state decode, so acceptance never loops back through req_valid
   assign req_ready = (state == ST_READY);
   assign acc       = req_valid & req_ready;
   assign in_range  = {1'b0, req_addr} < DEPTH_L;
   assign idx       = req_addr[AW-1:0];
   assign rd_acc    = acc & ~req_write;
   assign wr_acc    = acc & req_write & in_range;
   assign rd_word   = in_range ? mem[idx] : '0;

`ifdef MEM_CLEAR_EN
   logic [AW-1:0] clr_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end else if (state == ST_CLEAR) begin
         clr_cnt <= clr_cnt + AW'(1);
         if (clr_cnt == AW'(DEPTH - 1)) begin
            state <= ST_READY;
         end
      end
   end

   assign busy = (state == ST_CLEAR);

   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) begin
         mem[clr_cnt] <= '0;
      end else if (wr_acc) begin
         for (int b = 0; b < BE_W; b++) begin
            if (req_be[b]) begin
               mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
         end
      end
   end
`else
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_CLEAR;
      end else begin
         state <= ST_READY;
      end
   end

   assign busy = 1'b0;

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         for (int b = 0; b < BE_W; b++) begin
            if (req_be[b]) begin
               mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
         end
      end
   end
`endif

   // Each stage loads only behind a valid, so the last stage holds rd_data between pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_pipe <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            d_pipe[i] <= '0;
         end
      end else begin
         v_pipe[0] <= rd_acc;
         if (rd_acc) begin
            d_pipe[0] <= rd_word;
         end
         for (int i = 1; i < RD_LAT; i++) begin
            v_pipe[i] <= v_pipe[i-1];
            if (v_pipe[i-1]) begin
               d_pipe[i] <= d_pipe[i-1];
            end
         end
      end
   end

   assign rd_valid = v_pipe[RD_LAT-1];
   assign rd_data  = d_pipe[RD_LAT-1];

endmodule

// File: tb/tb_mem_bank_pipe.sv
// tb/tb_mem_bank_pipe.sv - directed vector bench for mem_bank_pipe, four banks with read latency 1..4
// Clear-dependent expectations follow MEM_CLEAR_EN.
module tb_mem_bank_pipe;
   localparam int NI = 4;
`ifdef MEM_CLEAR_EN
   localparam int   CLR_CYC  = 16;
   localparam logic BUSY_RST = 1'b1;
`else
   localparam int   CLR_CYC  = 1;
   localparam logic BUSY_RST = 1'b0;
`endif

   typedef struct {
      int          inst;
      bit          wr;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid [NI];
   logic        req_ready [NI];
   logic        req_write [NI];
   logic [7:0]  req_addr  [NI];
   logic [31:0] req_wdata [NI];
   logic [3:0]  req_be    [NI];
   logic        rd_valid  [NI];
   logic [31:0] rd_data   [NI];
   logic        busy      [NI];

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_bank_pipe #(.WORD(32), .ADDR(8), .DEPTH(16), .RD_LAT(g + 1)) u_dut (
         .clk       (clk),
         .reset     (reset),
         .req_valid (req_valid[g]),
         .req_ready (req_ready[g]),
         .req_write (req_write[g]),
         .req_addr  (req_addr[g]),
         .req_wdata (req_wdata[g]),
         .req_be    (req_be[g]),
         .rd_valid  (rd_valid[g]),
         .rd_data   (rd_data[g]),
         .busy      (busy[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int k, input bit wr, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      req_write[k] = wr;
      req_addr[k]  = a;
      req_wdata[k] = d;
      req_be[k]    = be;
      req_valid[k] = 1'b1;
   endtask

   task automatic wait_ready(input int k, output int n, output int seen_rdv);
      n = 0;
      seen_rdv = 0;
      while (!req_ready[k] && n < 40) begin
         tick();
         n++;
         if (rd_valid[k]) seen_rdv++;
      end
   endtask

   task automatic apply_vec(input vec_t v);
      int k, n, lat, seen;
      k = v.inst;
      drive(k, v.wr, v.addr, v.wdata, v.be);
      n = 0;
      while (!req_ready[k] && n < 40) begin
         tick();
         n++;
      end
      chk("vec_ready", req_ready[k], 1'b1);
      tick();
      req_valid[k] = 1'b0;
      if (v.wr) begin
         seen = 0;
         for (int c = 0; c < 6; c++) begin
            if (rd_valid[k]) seen++;
            tick();
         end
         chk("vec_write_no_rdv", seen, 0);
      end else begin
         lat = 1;
         while (!rd_valid[k] && lat < 8) begin
            tick();
            lat++;
         end
         chk("vec_latency", lat, k + 1);
         chk("vec_rdata", rd_data[k], v.exp);
         tick();
         chk("vec_pulse_end", rd_valid[k], 1'b0);
         chk("vec_rdata_hold", rd_data[k], v.exp);
      end
   endtask

   initial begin
      vec_t vecs[$];
      int   n, seen, first, got;

      for (int k = 0; k < NI; k++) begin
         req_valid[k] = 1'b0;
         req_write[k] = 1'b0;
         req_addr[k]  = '0;
         req_wdata[k] = '0;
         req_be[k]    = '0;
      end
      reset = 1'b1;
      repeat (3) tick();
      for (int k = 0; k < NI; k++) begin
         chk("rst_ready", req_ready[k], 1'b0);
         chk("rst_busy", busy[k], BUSY_RST);
         chk("rst_rd_valid", rd_valid[k], 1'b0);
         chk("rst_rd_data", rd_data[k], 32'h0);
      end

      // Read held on bank 0 through the clear; must be accepted only once ready
      drive(0, 1'b0, 8'h05, 32'h0, 4'h0);
      reset = 1'b0;
      #1;
      chk("busy_after_release", busy[0], BUSY_RST);
      wait_ready(0, n, seen);
      chk("clear_cycles", n, CLR_CYC);
      chk("busy_after_clear", busy[0], 1'b0);
      chk("no_rdv_during_clear", seen, 0);
      tick();
      req_valid[0] = 1'b0;
      chk("t1_rd_valid", rd_valid[0], 1'b1);
`ifdef MEM_CLEAR_EN
      chk("t1_rd_data", rd_data[0], 32'h0);
`endif
      tick();
      chk("t1_pulse_end", rd_valid[0], 1'b0);

      // Read-after-write on the next cycle, RD_LAT=2
      drive(1, 1'b1, 8'h03, 32'hDEADBEEF, 4'hF);
      tick();
      chk("t2_write_no_rdv", rd_valid[1], 1'b0);
      drive(1, 1'b0, 8'h03, 32'h0, 4'h0);
      tick();
      req_valid[1] = 1'b0;
      chk("t2_lat1", rd_valid[1], 1'b0);
      tick();
      chk("t2_lat2", rd_valid[1], 1'b1);
      chk("t2_data", rd_data[1], 32'hDEADBEEF);
      tick();
      chk("t2_pulse_end", rd_valid[1], 1'b0);
      chk("t2_hold", rd_data[1], 32'hDEADBEEF);

      vecs.push_back('{0, 1'b1, 8'h07, 32'h11223344, 4'hF, 32'h0});
      vecs.push_back('{0, 1'b1, 8'h07, 32'hAABBCCDD, 4'h5, 32'h0});
      vecs.push_back('{0, 1'b0, 8'h07, 32'hFFFFFFFF, 4'hF, 32'h11BB33DD});
      vecs.push_back('{0, 1'b1, 8'h07, 32'h99999999, 4'h0, 32'h0});
      vecs.push_back('{0, 1'b0, 8'h07, 32'h0, 4'h0, 32'h11BB33DD});
      vecs.push_back('{2, 1'b1, 8'h01, 32'hA5A5A5A5, 4'hF, 32'h0});
      vecs.push_back('{2, 1'b1, 8'h01, 32'h5A5A5A5A, 4'h8, 32'h0});
      vecs.push_back('{2, 1'b0, 8'h01, 32'h0, 4'h0, 32'h5AA5A5A5});
      vecs.push_back('{2, 1'b1, 8'h01, 32'h00000000, 4'h2, 32'h0});
      vecs.push_back('{2, 1'b0, 8'h01, 32'h0, 4'h0, 32'h5AA500A5});
      vecs.push_back('{3, 1'b1, 8'h00, 32'h12345678, 4'hF, 32'h0});
      vecs.push_back('{3, 1'b1, 8'h20, 32'hFFFFFFFF, 4'hF, 32'h0});
      vecs.push_back('{3, 1'b0, 8'h20, 32'h0, 4'h0, 32'h00000000});
      vecs.push_back('{3, 1'b0, 8'h00, 32'h0, 4'h0, 32'h12345678});
      vecs.push_back('{3, 1'b0, 8'hFF, 32'h0, 4'hF, 32'h00000000});
      for (int i = 0; i < 10; i++) begin
         vecs.push_back('{2, 1'b1, 8'(i), 32'h100 + 32'(i), 4'hF, 32'h0});
      end
      for (int i = 0; i < vecs.size(); i++) begin
         apply_vec(vecs[i]);
      end

      // Back-to-back reads on bank 2 (RD_LAT=3)
      first = -1;
      got = 0;
      for (int c = 0; c < 16; c++) begin
         if (c < 10) drive(2, 1'b0, 8'(c), 32'hFFFFFFFF, 4'hF);
         else req_valid[2] = 1'b0;
         tick();
         if (rd_valid[2]) begin
            if (first < 0) first = c;
            chk("stream_data", rd_data[2], 32'h100 + 32'(got));
            chk("stream_slot", c, first + got);
            got++;
         end
      end
      chk("stream_count", got, 10);
      chk("stream_first", first, 2);

      // Reset after the 4th accepted read of a stream
      for (int c = 0; c < 4; c++) begin
         drive(2, 1'b0, 8'(c), 32'h0, 4'h0);
         tick();
      end
      chk("t5_pre_data", rd_data[2], 32'h101);
      reset = 1'b1;
      req_valid[2] = 1'b0;
      #1;
      chk("t5_rd_valid", rd_valid[2], 1'b0);
      chk("t5_rd_data", rd_data[2], 32'h0);
      chk("t5_busy", busy[2], BUSY_RST);
      chk("t5_ready", req_ready[2], 1'b0);
      seen = 0;
      repeat (3) begin
         tick();
         if (rd_valid[2]) seen++;
      end
      reset = 1'b0;
      wait_ready(2, n, got);
      chk("t5_no_rdv", seen + got, 0);
      chk("t5_clear_cycles", n, CLR_CYC);
`ifdef MEM_CLEAR_EN
      apply_vec('{2, 1'b0, 8'h00, 32'h0, 4'h0, 32'h0});
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/mem_bank_pipe.md
Name: mem_bank_pipe

Overview:
Parametrised single-port synchronous RAM bank. Generalises the fixed 32x64k data memory:
- configurable width, depth and read latency
- per-byte write enables
- valid/ready request handshake
- post-reset clear sequencer that zeroes the array before accepting traffic

Sits between the core's load/store unit and the backing array, replacing direct A/W/D/Q hookups.

Parameters:
WORD, 32, data width in bits; must be a multiple of 8
ADDR, 16, address width in bits (word-addressed)
DEPTH, 65536, number of implemented words; must satisfy DEPTH <= 2**ADDR
RD_LAT, 1, read latency in cycles; legal range 1..4
BE_W, WORD/8, byte-enable width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  bank accepts a request this cycle
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR  word address
req_wdata  input  WORD  write data
req_be  input  BE_W  byte enables for writes; bit i selects bits [8i+7:8i]
rd_valid  output  1  read data valid pulse
rd_data  output  WORD  read data
busy  output  1  clear sequence in progress

Behaviour:
- Reset is asynchronous, active-high, on port reset; clock is clk. While reset is high:
  - state = CLEAR, clear counter = 0
  - req_ready = 0, busy = 1
  - rd_valid = 0, rd_data = 0
  - read-latency pipeline flushed
- FSM states:
  - CLEAR: each cycle writes 0 to word[counter] and increments counter. At counter == DEPTH-1, that word is written and the next state is READY.
  - READY: terminal until next reset.
- busy = (state == CLEAR); req_ready = (state == READY). Both are registered state decodes, with no combinational path from req_valid.
- Clear duration: exactly DEPTH cycles from the first rising edge after reset deassertion. req_ready rises on the edge that completes the last clear write.
- Accept: a request is accepted on a rising edge with req_valid & req_ready. At most one request per cycle. Requests in CLEAR are ignored and not queued; the requester holds req_valid.
- Write:
  - Byte lanes with req_be[i]=1 update at the accept edge; other lanes are unchanged.
  - be = 0 is accepted as a no-op.
  - Writes produce no rd_valid.
- Read:
  - rd_valid pulses high for exactly one cycle, RD_LAT cycles after the accept edge.
  - rd_data carries word[req_addr] as of the accept edge, which includes all writes accepted on earlier edges.
  - Reads ignore req_be and req_wdata.
- Streaming: back-to-back reads return back-to-back, in order, one per cycle. Read-after-write to the same address on the next cycle returns the new data.
- rd_data holds its last value while rd_valid is low.
- Out of range (req_addr >= DEPTH):
  - write is accepted and discarded
  - read is accepted and returns 0 with normal rd_valid timing
- Reset mid-operation: in-flight reads are dropped (no rd_valid), and the clear sequence restarts from address 0. Writes already committed are overwritten by the clear.

Optional Feature:
Macro MEM_CLEAR_EN.
- Defined: CLEAR state and clear counter present as described above.
- Undefined:
  - FSM enters READY directly after reset deassertion: req_ready = 1 on the first cycle after reset release, busy tied 0.
  - Array contents after reset are unspecified (X in simulation).
  - All other behaviour is identical.

Test Plan:
1. DEPTH=16, RD_LAT=1, MEM_CLEAR_EN defined; release reset, hold req_valid read addr 5 -> busy high for 16 cycles, req_ready rises on the 16th edge, rd_valid one cycle after accept with rd_data = 0x00000000.
2. RD_LAT=2: write 0xDEADBEEF to addr 3 (be=4'hF), read addr 3 on next cycle -> rd_valid exactly 2 cycles after read accept, rd_data = 0xDEADBEEF.
3. Byte enables:
   - write 0x11223344 to addr 7 with be=4'hF
   - write 0xAABBCCDD to addr 7 with be=4'b0101
   - read addr 7 -> 0x11BB33DD
   - write with be=0 then read -> still 0x11BB33DD
4. Streaming: preload addr 0..9 with values 0x100+i, issue reads 0..9 on consecutive cycles with RD_LAT=3 -> 10 consecutive rd_valid cycles returning 0x100..0x109 in order, starting 3 cycles after the first accept.
5. Reset mid-stream: issue reads 0..9, assert reset after the 4th accept -> no further rd_valid, rd_data = 0, busy high. After release, a clear of DEPTH cycles occurs and addr 0 reads 0.
6. DEPTH=16, ADDR=8: write 0xFFFFFFFF to addr 0x20 then read addr 0x20 -> rd_data = 0. Read addr 0x00 -> 0, i.e. no aliasing.
